aes_decrypt: RTL and testbench

AES_DECRYPT -- requirements
Module: aes_decrypt

---
 rtl/aes_decrypt.sv | 207 ++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 decryptor. Expands the forward key schedule
// into an 11-entry round-key file, then runs one inverse round per cycle.
// Ports: clk; rst_n (sync, active-low); key/ct (128b in, byte 0 = MSB);
//        load (start strobe); pt (128b result); valid (pt holds result);
//        busy (block in progress, load ignored).
// Option: AES_DECRYPT_KEY_CACHE_EN keeps the expanded key and skips the
//         key expansion when the next block uses the same key.
module aes_decrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic [127:0] ct,
  input  logic         load,
  output logic [127:0] pt,
  output logic         valid,
  output logic         busy
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Rcon for rounds 1..10; upper entries pad the 4-bit index.
  localparam logic [0:15][7:0] RCON =
    128'h01020408102040801b36000000000000;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // InvShiftRows then InvSubBytes; byte 4c+r is row r, column c.
  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          ISBOX[s[127-8*(4*((c-r)&3)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a, x2, x4, x8;
    logic [7:0]   m9 [0:3];
    logic [7:0]   mb [0:3];
    logic [7:0]   md [0:3];
    logic [7:0]   me [0:3];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a  = s[127-8*(4*c+r) -: 8];
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        m9[r] = x8 ^ a;
        mb[r] = x8 ^ x2 ^ a;
        md[r] = x8 ^ x4 ^ a;
        me[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = me[r] ^ mb[(r+1)&3]
                              ^ md[(r+2)&3] ^ m9[(r+3)&3];
    end
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;

  fsm_t         r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_rk [0:10];
  logic [127:0] r_state;
  logic [127:0] r_pt;
  logic         r_valid;
  logic         r_busy;
`ifdef AES_DECRYPT_KEY_CACHE_EN
  logic         r_kc;
`endif

  logic [127:0] w_kprev;
  logic [31:0]  w_temp;
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [127:0] w_knext;
  logic [127:0] w_rnd;
  logic [127:0] w_mix;

  // Forward schedule step: rk[r_cnt] -> rk[r_cnt+1].
  assign w_kprev = r_rk[r_cnt];
  assign w_temp  = {SBOX[w_kprev[23:16]] ^ RCON[r_cnt],
                    SBOX[w_kprev[15:8]],
                    SBOX[w_kprev[7:0]],
                    SBOX[w_kprev[31:24]]};
  assign w_k0    = w_kprev[127:96] ^ w_temp;
  assign w_k1    = w_kprev[95:64]  ^ w_k0;
  assign w_k2    = w_kprev[63:32]  ^ w_k1;
  assign w_k3    = w_kprev[31:0]   ^ w_k2;
  assign w_knext = {w_k0, w_k1, w_k2, w_k3};

  // Round 0 result is w_rnd directly; rounds 9..1 add InvMixColumns.
  assign w_rnd = inv_sr_sb(r_state) ^ r_rk[r_cnt];
  assign w_mix = inv_mix(w_rnd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_cnt   <= 4'd0;
      r_pt    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef AES_DECRYPT_KEY_CACHE_EN
      r_kc    <= 1'b0;
`endif
    end else begin
      unique case (r_fsm)
        IDLE: begin
          if (load) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
`ifdef AES_DECRYPT_KEY_CACHE_EN
            if (r_kc && key == r_rk[0]) begin
              r_state <= ct ^ r_rk[10];
              r_cnt   <= 4'd9;
              r_fsm   <= DEC;
            end else begin
              r_kc    <= 1'b0;
              r_rk[0] <= key;
              r_state <= ct;
              r_cnt   <= 4'd0;
              r_fsm   <= KEXP;
            end
`else
            r_rk[0] <= key;
            r_state <= ct;
            r_cnt   <= 4'd0;
            r_fsm   <= KEXP;
`endif
          end
        end
        KEXP: begin
          r_rk[r_cnt + 4'd1] <= w_knext;
          if (r_cnt == 4'd9) begin
            // r_state still holds ct; fold in rk[10] as it is produced.
            r_state <= r_state ^ w_knext;
            r_fsm   <= DEC;
`ifdef AES_DECRYPT_KEY_CACHE_EN
            r_kc    <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DEC: begin
          if (r_cnt == 4'd0) begin
            r_pt    <= w_rnd;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_fsm   <= IDLE;
          end else begin
            r_state <= w_mix;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign pt    = r_pt;
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: scoreboard bench for aes_decrypt using FIPS-197
// vectors; expected plaintext and latency are queued at each accept.
module tb_aes_decrypt;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ct = '0;
  logic         load = 1'b0;
  logic [127:0] pt;
  logic         valid;
  logic         busy;

  always #5 clk = ~clk;

  aes_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .ct    (ct),
    .load  (load),
    .pt    (pt),
    .valid (valid),
    .busy  (busy)
  );

  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;

`ifdef AES_DECRYPT_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct packed {
    logic [127:0] pt;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  bit           m_cv = 1'b0;
  logic [127:0] m_ck = '0;

  // Reference latency: short only on a repeat of the retained key.
  task automatic push_exp(input logic [127:0] k, input logic [127:0] p);
    exp_t e;
    e.pt  = p;
    e.lat = (CACHE && m_cv && k == m_ck) ? 10 : 20;
    sb.push_back(e);
    m_cv = 1'b1;
    m_ck = k;
  endtask

  // Returns at the falling edge after the accepting edge.
  task automatic start_block(input logic [127:0] k, input logic [127:0] c,
                             input logic [127:0] p, input bit hold);
    push_exp(k, p);
    @(negedge clk);
    key  = k;
    ct   = c;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) load = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (valid) lat = n;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if (pt !== '0) $display("FAIL reset_pt: got %h want 0", pt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m_cv = 1'b0;
  endtask

  task automatic test_c1;
    exp_t e;
    int   lat;
    logic [127:0] hold_pt;
    start_block(C1_K, C1_C, C1_P, 1'b0);
    n_chk++;
    if (busy !== 1'b1 || valid !== 1'b0)
      $display("FAIL c1_accept: busy=%b valid=%b want 1/0", busy, valid);
    else n_pass++;
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat) $display("FAIL c1_lat: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_chk++;
    if (pt !== e.pt) $display("FAIL c1_pt: got %h want %h", pt, e.pt);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL c1_busy_done: got %b want 0", busy);
    else n_pass++;
    hold_pt = pt;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (valid !== 1'b1 || pt !== C1_P)
      $display("FAIL c1_hold: valid=%b pt=%h want 1/%h", valid, pt, C1_P);
    else n_pass++;
    n_chk++;
    if (pt !== hold_pt) $display("FAIL c1_stable: got %h want %h", pt, hold_pt);
    else n_pass++;
  endtask

  task automatic test_b;
    exp_t e;
    int   lat;
    start_block(B_K, B_C, B_P, 1'b0);
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat) $display("FAIL b_lat: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_chk++;
    if (pt !== e.pt) $display("FAIL b_pt: got %h want %h", pt, e.pt);
    else n_pass++;
  endtask

  task automatic test_ignored_load;
    exp_t e;
    int   lat = -1;
    int   rises = 0;
    int   busy_bad = 0;
    bit   pv = 1'b0;
    start_block(C1_K, C1_C, C1_P, 1'b0);
    for (int n = 1; n <= 30; n++) begin
      load = (n == 3 || n == 10 || n == 15);
      @(posedge clk);
      #1;
      if (valid && !pv) begin
        rises++;
        if (lat < 0) lat = n;
      end
      pv = valid;
      if (lat < 0 && !busy) busy_bad++;
      @(negedge clk);
    end
    load = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat) $display("FAIL ign_lat: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_chk++;
    if (rises !== 1) $display("FAIL ign_rises: got %0d want 1", rises);
    else n_pass++;
    n_chk++;
    if (busy_bad !== 0) $display("FAIL ign_busy: got %0d want 0", busy_bad);
    else n_pass++;
    n_chk++;
    if (pt !== e.pt) $display("FAIL ign_pt: got %h want %h", pt, e.pt);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL ign_idle: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    exp_t e;
    int   lat;
    int   vcnt = 0;
    start_block(C1_K, C1_C, C1_P, 1'b0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e = sb.pop_front();
    m_cv = 1'b0;
    n_chk++;
    if (valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_flags: valid=%b busy=%b want 0/0", valid, busy);
    else n_pass++;
    n_chk++;
    if (pt !== '0) $display("FAIL rst_pt: got %h want 0", pt);
    else n_pass++;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (valid) vcnt++;
    end
    n_chk++;
    if (vcnt !== 0) $display("FAIL rst_novalid: got %0d want 0", vcnt);
    else n_pass++;
    start_block(C1_K, C1_C, C1_P, 1'b0);
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat) $display("FAIL rst_lat: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_chk++;
    if (pt !== e.pt) $display("FAIL rst_pt2: got %h want %h", pt, e.pt);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   lat;
    logic [127:0] ks [0:3];
    logic [127:0] cs [0:3];
    logic [127:0] ps [0:3];
    ks[0] = B_K;  cs[0] = B_C;  ps[0] = B_P;
    ks[1] = C1_K; cs[1] = C1_C; ps[1] = C1_P;
    ks[2] = C1_K; cs[2] = C1_C; ps[2] = C1_P;
    ks[3] = B_K;  cs[3] = B_C;  ps[3] = B_P;
    for (int i = 0; i < 4; i++) begin
      start_block(ks[i], cs[i], ps[i], 1'b0);
      wait_valid(lat);
      e = sb.pop_front();
      n_chk++;
      if (lat !== e.lat)
        $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      else n_pass++;
      n_chk++;
      if (pt !== e.pt)
        $display("FAIL b2b_pt[%0d]: got %h want %h", i, pt, e.pt);
      else n_pass++;
    end
  endtask

  task automatic test_input_change;
    exp_t e;
    int   lat;
    start_block(C1_K, C1_C, C1_P, 1'b0);
    key = '1;
    ct  = '1;
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat) $display("FAIL chg_lat: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_chk++;
    if (pt !== e.pt) $display("FAIL chg_pt: got %h want %h", pt, e.pt);
    else n_pass++;
  endtask

  task automatic test_load_held;
    exp_t e;
    int   lat;
    start_block(C1_K, C1_C, C1_P, 1'b1);
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat) $display("FAIL held_lat1: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_chk++;
    if (pt !== e.pt) $display("FAIL held_pt1: got %h want %h", pt, e.pt);
    else n_pass++;
    push_exp(C1_K, C1_P);
    @(posedge clk);
    #1;
    n_chk++;
    if (valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL held_reaccept: valid=%b busy=%b want 0/1", valid, busy);
    else n_pass++;
    n_chk++;
    if (pt !== C1_P) $display("FAIL held_oldpt: got %h want %h", pt, C1_P);
    else n_pass++;
    @(negedge clk);
    load = 1'b0;
    wait_valid(lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== e.lat) $display("FAIL held_lat2: got %0d want %0d", lat, e.lat);
    else n_pass++;
    n_chk++;
    if (pt !== e.pt) $display("FAIL held_pt2: got %h want %h", pt, e.pt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_c1();
    test_b();
    test_ignored_load();
    test_mid_reset();
    test_back_to_back();
    test_input_change();
    test_load_held();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
